// File: rtl/lc3_decode_stage.sv
// LC3 decode stage: registers the fetched instruction, builds the execute-stage
// control words and raises operand bypass selects against a 2-deep issue history.
module lc3_decode_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter bit          HIST_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
    output logic              bypass_alu_1,
    output logic              bypass_alu_2,
    output logic              bypass_mem_1,
    output logic              bypass_mem_2,
    output logic              dec_valid
);

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpLea = 4'b1110;

    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_npc;
    logic [5:0]        r_e_ctl;
    logic [1:0]        r_w_ctl;
    logic              r_m_ctl;
    logic              r_ba1;
    logic              r_ba2;
    logic              r_bm1;
    logic              r_bm2;
    logic              r_valid;
    // Writeback slot keeps only the fields the hazard check looks at.
    logic [3:0]        r_wb_op;
    logic [2:0]        r_wb_dr;
    logic              r_wb_v;

    logic [3:0] w_op;
    logic [5:0] w_e_ctl;
    logic [1:0] w_w_ctl;
    logic       w_m_ctl;
    logic [2:0] w_sr1;
    logic [2:0] w_sr2;
    logic       w_use_sr1;
    logic       w_use_sr2;
    logic       w_ex_alu;
    logic       w_wb_load;
    logic       w_ba1;
    logic       w_ba2;
    logic       w_bm1;
    logic       w_bm2;

    assign w_op = dout[15:12];

    // Control words and source-register usage of the incoming instruction.
    always_comb begin
        w_e_ctl   = 6'b000000;
        w_w_ctl   = 2'd0;
        w_m_ctl   = 1'b0;
        w_sr1     = dout[8:6];
        w_sr2     = dout[2:0];
        w_use_sr1 = 1'b0;
        w_use_sr2 = 1'b0;
        case (w_op)
            OpAdd: begin
                w_e_ctl   = {5'b00000, ~dout[5]};
                w_use_sr1 = 1'b1;
                w_use_sr2 = ~dout[5];
            end
            OpAnd: begin
                w_e_ctl   = {5'b01000, ~dout[5]};
                w_use_sr1 = 1'b1;
                w_use_sr2 = ~dout[5];
            end
            OpNot: begin
                w_e_ctl   = 6'b100000;
                w_use_sr1 = 1'b1;
            end
            OpBr:  w_e_ctl = 6'b000110;
            OpLd: begin
                w_e_ctl = 6'b000110;
                w_w_ctl = 2'd2;
            end
            OpLdi: begin
                w_e_ctl = 6'b000110;
                w_w_ctl = 2'd2;
                w_m_ctl = 1'b1;
            end
            OpLea: begin
                w_e_ctl = 6'b000110;
                w_w_ctl = 2'd1;
            end
            OpSt: begin
                w_e_ctl   = 6'b000110;
                w_sr2     = dout[11:9];
                w_use_sr2 = 1'b1;
            end
            OpSti: begin
                w_e_ctl   = 6'b000110;
                w_m_ctl   = 1'b1;
                w_sr2     = dout[11:9];
                w_use_sr2 = 1'b1;
            end
            OpLdr: begin
                w_e_ctl   = 6'b001000;
                w_w_ctl   = 2'd2;
                w_use_sr1 = 1'b1;
            end
            OpStr: begin
                w_e_ctl   = 6'b001000;
                w_use_sr1 = 1'b1;
                w_sr2     = dout[11:9];
                w_use_sr2 = 1'b1;
            end
            OpJmp: begin
                w_e_ctl   = 6'b001100;
                w_use_sr1 = 1'b1;
            end
            default: w_e_ctl = 6'b000000;
        endcase
    end

    // Hazard detection: the execute-slot ALU producer outranks the writeback-slot load.
    always_comb begin
        w_ex_alu  = r_valid && (r_ir[15:12] == OpAdd || r_ir[15:12] == OpAnd ||
                                r_ir[15:12] == OpNot);
        w_wb_load = r_wb_v && (r_wb_op == OpLd || r_wb_op == OpLdr || r_wb_op == OpLdi);
        w_ba1     = HIST_EN && w_ex_alu && w_use_sr1 && (r_ir[11:9] == w_sr1);
        w_ba2     = HIST_EN && w_ex_alu && w_use_sr2 && (r_ir[11:9] == w_sr2);
        w_bm1     = HIST_EN && w_wb_load && w_use_sr1 && (r_wb_dr == w_sr1) && !w_ba1;
        w_bm2     = HIST_EN && w_wb_load && w_use_sr2 && (r_wb_dr == w_sr2) && !w_ba2;
    end

    // Pipeline register and history shift; reset wins over enable, hold inserts no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir    <= '0;
            r_npc   <= '0;
            r_e_ctl <= '0;
            r_w_ctl <= '0;
            r_m_ctl <= 1'b0;
            r_ba1   <= 1'b0;
            r_ba2   <= 1'b0;
            r_bm1   <= 1'b0;
            r_bm2   <= 1'b0;
            r_valid <= 1'b0;
            r_wb_op <= '0;
            r_wb_dr <= '0;
            r_wb_v  <= 1'b0;
        end else if (enable_decode) begin
            r_wb_op <= r_ir[15:12];
            r_wb_dr <= r_ir[11:9];
            r_wb_v  <= r_valid;
            r_ir    <= dout;
            r_npc   <= npc_in;
            r_e_ctl <= w_e_ctl;
            r_w_ctl <= w_w_ctl;
            r_m_ctl <= w_m_ctl;
            r_ba1   <= w_ba1;
            r_ba2   <= w_ba2;
            r_bm1   <= w_bm1;
            r_bm2   <= w_bm2;
            r_valid <= 1'b1;
        end
    end

    assign IR           = r_ir;
    assign npc_out      = r_npc;
    assign E_control    = r_e_ctl;
    assign W_Control    = r_w_ctl;
    assign Mem_Control  = r_m_ctl;
    assign bypass_alu_1 = r_ba1;
    assign bypass_alu_2 = r_ba2;
    assign bypass_mem_1 = r_bm1;
    assign bypass_mem_2 = r_bm2;
    assign dec_valid    = r_valid;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        dec_valid;

    int checks   = 0;
    int failures = 0;

    lc3_decode_stage #(
        .DATA_W  (16),
        .HIST_EN (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_control     (E_control),
        .W_Control     (W_Control),
        .Mem_Control   (Mem_Control),
        .bypass_alu_1  (bypass_alu_1),
        .bypass_alu_2  (bypass_alu_2),
        .bypass_mem_1  (bypass_mem_1),
        .bypass_mem_2  (bypass_mem_2),
        .dec_valid     (dec_valid)
    );

    always #5 clock = ~clock;

    logic [45:0] act_all;
    assign act_all = {IR, npc_out, E_control, W_Control, Mem_Control,
                      bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, dec_valid};

    // Reference model: issued-instruction history, newest first.
    logic [15:0] hist_ir [2];
    logic        hist_v  [2];
    logic [15:0] m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_m;
    logic        m_ba [2];
    logic        m_bm [2];

    function automatic logic [5:0] ref_e(input logic [15:0] i);
        case (i[15:12])
            4'b0001: return {5'b00000, ~i[5]};
            4'b0101: return {5'b01000, ~i[5]};
            4'b1001: return 6'b100000;
            4'b0000, 4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011: return 6'b000110;
            4'b0110, 4'b0111: return 6'b001000;
            4'b1100: return 6'b001100;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [1:0] ref_w(input logic [15:0] i);
        if (i[15:12] == 4'b1110) return 2'd1;
        if (i[15:12] == 4'b0010 || i[15:12] == 4'b0110 || i[15:12] == 4'b1010) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit is_alu(input logic [15:0] i);
        return i[15:12] == 4'b0001 || i[15:12] == 4'b0101 || i[15:12] == 4'b1001;
    endfunction

    function automatic bit is_load(input logic [15:0] i);
        return i[15:12] == 4'b0010 || i[15:12] == 4'b0110 || i[15:12] == 4'b1010;
    endfunction

    // Source register n (0 = SR1, 1 = SR2) of an instruction, or -1 if unused.
    function automatic int src_reg(input logic [15:0] i, input int n);
        int op;
        op = int'(i[15:12]);
        if (n == 0) begin
            if (op == 1 || op == 5 || op == 9 || op == 12 || op == 6 || op == 7)
                return int'(i[8:6]);
            return -1;
        end
        if ((op == 1 || op == 5) && !i[5]) return int'(i[2:0]);
        if (op == 3 || op == 7 || op == 11) return int'(i[11:9]);
        return -1;
    endfunction

    function automatic logic [45:0] exp_all();
        return {hist_ir[0], m_npc, m_e, m_w, m_m, m_ba[0], m_ba[1], m_bm[0], m_bm[1],
                hist_v[0]};
    endfunction

    task automatic model_update(input logic r, input logic en, input logic [15:0] d,
                                input logic [15:0] n);
        int s;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                hist_ir[k] = '0;
                hist_v[k]  = 1'b0;
                m_ba[k]    = 1'b0;
                m_bm[k]    = 1'b0;
            end
            m_npc = '0;
            m_e   = '0;
            m_w   = '0;
            m_m   = 1'b0;
        end else if (en) begin
            for (int k = 0; k < 2; k++) begin
                s       = src_reg(d, k);
                m_ba[k] = s >= 0 && hist_v[0] && is_alu(hist_ir[0]) &&
                          int'(hist_ir[0][11:9]) == s;
                m_bm[k] = s >= 0 && hist_v[1] && is_load(hist_ir[1]) &&
                          int'(hist_ir[1][11:9]) == s && !m_ba[k];
            end
            hist_ir[1] = hist_ir[0];
            hist_v[1]  = hist_v[0];
            hist_ir[0] = d;
            hist_v[0]  = 1'b1;
            m_npc      = n;
            m_e        = ref_e(d);
            m_w        = ref_w(d);
            m_m        = d[15:12] == 4'b1010 || d[15:12] == 4'b1011;
        end
    endtask

    // Drive one cycle, advance the model at the edge, return 1 time unit after it.
    task automatic step(input logic r, input logic en, input logic [15:0] d,
                        input logic [15:0] n);
        reset         = r;
        enable_decode = en;
        dout          = d;
        npc_in        = n;
        @(posedge clock);
        model_update(r, en, d, n);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 16'h1042, 16'h1234);
        step(1'b1, 1'b1, 16'h1042, 16'h1234);
        checks++;
        if (act_all !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, want 0", act_all);
        end
        checks++;
        if (dec_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_dec_valid: got %b, want 0", dec_valid);
        end
    endtask

    task automatic test_add_basic();
        step(1'b0, 1'b1, 16'h1283, 16'h3001);
        checks++;
        if (IR !== 16'h1283 || npc_out !== 16'h3001) begin
            failures++;
            $display("FAIL add_ir_npc: got IR=%h npc=%h, want 1283/3001", IR, npc_out);
        end
        checks++;
        if (E_control !== 6'b000001 || W_Control !== 2'd0 || dec_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_ctl: got E=%b W=%0d v=%b, want 000001/0/1",
                     E_control, W_Control, dec_valid);
        end
    endtask

    task automatic test_alu_bypass();
        step(1'b0, 1'b1, 16'h1283, 16'h3002);
        step(1'b0, 1'b1, 16'h5460, 16'h3003);
        checks++;
        if (bypass_alu_1 !== 1'b1 || bypass_alu_2 !== 1'b0) begin
            failures++;
            $display("FAIL alu_bypass: got a1=%b a2=%b, want 1/0", bypass_alu_1, bypass_alu_2);
        end
        checks++;
        if (E_control !== 6'b010000) begin
            failures++;
            $display("FAIL and_imm_ctl: got %b, want 010000", E_control);
        end
    endtask

    task automatic test_mem_bypass();
        step(1'b0, 1'b1, 16'h2205, 16'h3004);
        checks++;
        if (W_Control !== 2'd2 || bypass_alu_1 !== 1'b0) begin
            failures++;
            $display("FAIL ld_ctl: got W=%0d a1=%b, want 2/0", W_Control, bypass_alu_1);
        end
        step(1'b0, 1'b1, 16'h0000, 16'h3005);
        step(1'b0, 1'b1, 16'h1441, 16'h3006);
        checks++;
        if ({bypass_mem_1, bypass_mem_2, bypass_alu_1, bypass_alu_2} !== 4'b1100) begin
            failures++;
            $display("FAIL mem_bypass: got m1m2a1a2=%b, want 1100",
                     {bypass_mem_1, bypass_mem_2, bypass_alu_1, bypass_alu_2});
        end
    endtask

    task automatic test_ldi_hold();
        logic [45:0] held;
        step(1'b0, 1'b1, 16'hA405, 16'h3007);
        checks++;
        if (Mem_Control !== 1'b1 || W_Control !== 2'd2 || E_control !== 6'b000110) begin
            failures++;
            $display("FAIL ldi_ctl: got M=%b W=%0d E=%b, want 1/2/000110",
                     Mem_Control, W_Control, E_control);
        end
        held = exp_all();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'h1441 + 16'(k), 16'h4000 + 16'(k));
            checks++;
            if (act_all !== held) begin
                failures++;
                $display("FAIL hold_%0d: got %h, want %h", k, act_all, held);
            end
        end
        // Held IR (LDI R2) is not an ALU op; wb slot holds the ADD, so no bypass.
        step(1'b0, 1'b1, 16'h1480, 16'h3008);
        checks++;
        if (act_all !== exp_all()) begin
            failures++;
            $display("FAIL after_hold: got %h, want %h", act_all, exp_all());
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 16'h1283, 16'h3009);
        step(1'b1, 1'b1, 16'h1441, 16'h300A);
        checks++;
        if (act_all !== 46'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h, want 0", act_all);
        end
        step(1'b0, 1'b1, 16'h1441, 16'h300B);
        checks++;
        if (bypass_alu_1 !== 1'b0 || bypass_alu_2 !== 1'b0 || IR !== 16'h1441) begin
            failures++;
            $display("FAIL post_reset_no_bypass: got a1=%b a2=%b IR=%h, want 0/0/1441",
                     bypass_alu_1, bypass_alu_2, IR);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        en;
        logic        r;
        for (int c = 0; c < 400; c++) begin
            d       = 16'($urandom);
            d[11:9] = 3'($urandom_range(0, 1));
            d[8:6]  = 3'($urandom_range(0, 1));
            d[2:0]  = 3'($urandom_range(0, 1));
            en      = $urandom_range(0, 3) != 0;
            r       = $urandom_range(0, 40) == 0;
            step(r, en, d, 16'($urandom));
            checks++;
            if (act_all !== exp_all()) begin
                failures++;
                $display("FAIL random_%0d: got %h, want %h (dout=%h en=%b rst=%b)",
                         c, act_all, exp_all(), d, en, r);
            end
            checks++;
            if ((bypass_alu_1 && bypass_mem_1) || (bypass_alu_2 && bypass_mem_2)) begin
                failures++;
                $display("FAIL random_excl_%0d: got a1m1a2m2=%b, want no pair both set", c,
                         {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2});
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable_decode = 1'b0;
        dout          = '0;
        npc_in        = '0;
        model_update(1'b1, 1'b0, 16'h0, 16'h0);
        test_reset();
        test_add_basic();
        test_alu_bypass();
        test_mem_bypass();
        test_ldi_hold();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
